// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - write-back arbiter bus: issue, ALU, LSU and register file write port
interface wb_arbiter_if;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] pending;

  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output RegWrite, rd, wd, pending
  );

  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  RegWrite, rd, wd, pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - ALU FIFO + LSU write-back merge with pending scoreboard; WB_ROUNDROBIN_EN selects round-robin
module wb_arbiter #(
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(ALU_FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    fifo_rd   [ALU_FIFO_DEPTH];
  logic [31:0]   fifo_data [ALU_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          alu_ready_q;
  logic          alu_ready_int;
  logic          lsu_ready_int;
  logic          fifo_nonempty;
  logic          push;
  logic          pop;
  logic          grant_lsu;
  logic          grant_alu;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic          regwrite_q;
  logic [4:0]    rd_q;
  logic [31:0]   wd_q;
  logic [31:0]   pending_q;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

`ifdef WB_ROUNDROBIN_EN
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;
  logic last_grant;
`endif

  // Arbitration, FIFO occupancy and scoreboard masks.
  always_comb begin
    fifo_nonempty = (count != '0);
`ifdef WB_ROUNDROBIN_EN
    lsu_ready_int = !rst && !(fifo_nonempty && last_grant == GRANT_LSU);
`else
    lsu_ready_int = !rst;
`endif
    alu_ready_int = alu_ready_q && !rst;
    push      = bus.alu_valid && alu_ready_int;
    grant_lsu = bus.lsu_valid && lsu_ready_int;
    grant_alu = fifo_nonempty && !grant_lsu;
    pop       = grant_alu;
    sel_rd    = grant_lsu ? bus.lsu_rd   : fifo_rd[rd_ptr];
    sel_data  = grant_lsu ? bus.lsu_data : fifo_data[rd_ptr];
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
    set_mask = bus.issue_valid ? (32'd1 << bus.issue_rd) : 32'd0;
    clr_mask = regwrite_q ? (32'd1 << rd_q) : 32'd0;
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.alu_rd;
      fifo_data[wr_ptr] <= bus.alu_data;
    end
  end

  // FIFO pointers and registered ready; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      alu_ready_q <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      alu_ready_q <= (count_next != CW'(ALU_FIFO_DEPTH));
    end
  end

`ifdef WB_ROUNDROBIN_EN
  // Remember which source won last so contention alternates.
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= GRANT_ALU;
    else if (grant_lsu)
      last_grant <= GRANT_LSU;
    else if (grant_alu)
      last_grant <= GRANT_ALU;
  end
`endif

  // Register file write port; x0 results are consumed but never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wd_q       <= 32'd0;
    end else if (grant_lsu || grant_alu) begin
      regwrite_q <= (sel_rd != 5'd0);
      rd_q       <= sel_rd;
      wd_q       <= sel_data;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  // Pending scoreboard: a new issue beats the completing write to the same register.
  always_ff @(posedge clk) begin
    if (rst)
      pending_q <= 32'd0;
    else
      pending_q <= ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  assign bus.alu_ready = alu_ready_int;
  assign bus.lsu_ready = lsu_ready_int;
  assign bus.RegWrite  = regwrite_q;
  assign bus.rd        = rd_q;
  assign bus.wd        = wd_q;
  assign bus.pending   = pending_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector bench for wb_arbiter
module tb_wb_arbiter;
  logic clk;
  logic rst;
  wb_arbiter_if bus();

  wb_arbiter #(.ALU_FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  ird;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        ar;
    logic        lr;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pend;
  } vec_t;

  vec_t vecs[$];
  int   nchecks = 0;
  int   nerrors = 0;

  task automatic add(input int r, input int iv, input int ird, input int av, input int ard,
                     input int adat, input int lv, input int lrd, input int ldat,
                     input int ar, input int lr, input int rw, input int erd,
                     input int ewd, input int ep);
    vec_t v;
    v.rst = 1'(r);   v.iv = 1'(iv);   v.ird = 5'(ird);
    v.av = 1'(av);   v.ard = 5'(ard); v.adat = 32'(adat);
    v.lv = 1'(lv);   v.lrd = 5'(lrd); v.ldat = 32'(ldat);
    v.ar = 1'(ar);   v.lr = 1'(lr);   v.rw = 1'(rw);
    v.rd = 5'(erd);  v.wd = 32'(ewd); v.pend = 32'(ep);
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s row %0d actual=%h expected=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst;
    bus.issue_valid = v.iv;
    bus.issue_rd    = v.ird;
    bus.alu_valid   = v.av;
    bus.alu_rd      = v.ard;
    bus.alu_data    = v.adat;
    bus.lsu_valid   = v.lv;
    bus.lsu_rd      = v.lrd;
    bus.lsu_data    = v.ldat;
  endtask

  task automatic idle();
    vec_t v;
    v = '{default: '0};
    drive(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit found;
    vec_t v;

    // rst iv ird  av ard adat  lv lrd ldat  | ar lr rw rd wd pending
    add(1, 0,0, 0,0,0,         0,0,0,              0,0, 0,0,0,0);
    add(1, 0,0, 0,0,0,         0,0,0,              0,0, 0,0,0,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,0,0,0);
    add(0, 0,0, 0,0,0,         1,5,32'hDEADBEEF,   1,1, 0,0,0,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 1,5,32'hDEADBEEF,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,5,32'hDEADBEEF,0);
    add(0, 0,0, 1,0,1,         0,0,0,              1,1, 0,5,32'hDEADBEEF,0);
    add(0, 0,0, 1,7,2,         0,0,0,              1,1, 0,5,32'hDEADBEEF,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,0,1,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 1,7,2,0);
    add(0, 1,9, 0,0,0,         0,0,0,              1,1, 0,7,2,0);
    add(0, 0,0, 0,0,0,         1,9,32'h99,         1,1, 0,7,2,32'h200);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 1,9,32'h99,32'h200);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,9,32'h99,0);
    add(0, 1,9, 0,0,0,         0,0,0,              1,1, 0,9,32'h99,0);
    add(0, 0,0, 0,0,0,         1,9,32'h55,         1,1, 0,9,32'h99,32'h200);
    add(0, 1,9, 0,0,0,         0,0,0,              1,1, 1,9,32'h55,32'h200);
    add(0, 1,0, 0,0,0,         0,0,0,              1,1, 0,9,32'h55,32'h200);
`ifdef WB_ROUNDROBIN_EN
    add(0, 0,0, 1,2,32'h22,    1,1,32'h11,         1,1, 0,9,32'h55,32'h200);
    add(0, 0,0, 1,4,32'h44,    1,3,32'h33,         1,0, 1,1,32'h11,32'h200);
    add(0, 0,0, 1,6,32'h66,    1,3,32'h33,         1,1, 1,2,32'h22,32'h200);
    add(0, 0,0, 0,0,0,         1,5,32'h5555,       0,0, 1,3,32'h33,32'h200);
    add(0, 0,0, 0,0,0,         1,5,32'h5555,       1,1, 1,4,32'h44,32'h200);
    add(0, 0,0, 0,0,0,         1,8,32'h88,         1,0, 1,5,32'h5555,32'h200);
    add(0, 0,0, 0,0,0,         1,8,32'h88,         1,1, 1,6,32'h66,32'h200);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 1,8,32'h88,32'h200);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,8,32'h88,32'h200);
    add(0, 1,3, 1,10,32'hA,    1,11,32'hB,         1,1, 0,8,32'h88,32'h200);
    add(0, 0,0, 1,12,32'hC,    1,13,32'hD,         1,0, 1,11,32'hB,32'h208);
    add(0, 0,0, 1,15,32'hF,    1,13,32'hD,         1,1, 1,10,32'hA,32'h208);
    add(1, 0,0, 0,0,0,         0,0,0,              0,0, 1,13,32'hD,32'h208);
`else
    add(0, 0,0, 1,2,32'h22,    1,1,32'h11,         1,1, 0,9,32'h55,32'h200);
    add(0, 0,0, 1,4,32'h44,    1,3,32'h33,         1,1, 1,1,32'h11,32'h200);
    add(0, 0,0, 1,6,32'h66,    1,5,32'h5555,       0,1, 1,3,32'h33,32'h200);
    add(0, 0,0, 1,6,32'h66,    1,8,32'h88,         0,1, 1,5,32'h5555,32'h200);
    add(0, 0,0, 1,6,32'h66,    0,0,0,              0,1, 1,8,32'h88,32'h200);
    add(0, 0,0, 1,6,32'h66,    0,0,0,              1,1, 1,2,32'h22,32'h200);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 1,4,32'h44,32'h200);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 1,6,32'h66,32'h200);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,6,32'h66,32'h200);
    add(0, 1,3, 1,10,32'hA,    1,11,32'hB,         1,1, 0,6,32'h66,32'h200);
    add(0, 0,0, 1,12,32'hC,    1,13,32'hD,         1,1, 1,11,32'hB,32'h208);
    add(1, 0,0, 0,0,0,         0,0,0,              0,0, 1,13,32'hD,32'h208);
`endif
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,0,0,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,0,0,0);
    add(0, 0,0, 1,14,32'hE,    0,0,0,              1,1, 0,0,0,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,0,0,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 1,14,32'hE,0);
    add(0, 0,0, 0,0,0,         0,0,0,              1,1, 0,14,32'hE,0);

    idle();
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      @(negedge clk);
      chk("alu_ready", i, 32'(bus.alu_ready), 32'(v.ar));
      chk("lsu_ready", i, 32'(bus.lsu_ready), 32'(v.lr));
      chk("RegWrite",  i, 32'(bus.RegWrite),  32'(v.rw));
      chk("rd",        i, 32'(bus.rd),        32'(v.rd));
      chk("wd",        i, bus.wd,             v.wd);
      chk("pending",   i, bus.pending,        v.pend);
      @(posedge clk); #1;
    end

    // Back-to-back LSU results: one write per cycle.
    for (int i = 0; i < 6; i++) begin
      idle();
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'(i + 1);
      bus.lsu_data  = 32'h100 + 32'(i);
      @(negedge clk);
      chk("stream_lsu_ready", i, 32'(bus.lsu_ready), 32'd1);
      chk("stream_RegWrite",  i, 32'(bus.RegWrite), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("stream_rd", i, 32'(bus.rd), 32'(i));
        chk("stream_wd", i, bus.wd, 32'h100 + 32'(i - 1));
      end
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    chk("stream_last_rd", 6, 32'(bus.rd), 32'd6);
    chk("stream_last_wd", 6, bus.wd, 32'h105);
    @(posedge clk); #1;

    // Single ALU push: the write must appear exactly two cycles later.
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd20;
    bus.alu_data  = 32'hABC;
    @(negedge clk);
    chk("lat_alu_ready", 0, 32'(bus.alu_ready), 32'd1);
    chk("lat_RegWrite0", 0, 32'(bus.RegWrite), 32'd0);
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 8 && !found; k++) begin
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      if (bus.RegWrite) begin
        found = 1'b1;
        lat = k;
      end
    end
    chk("alu_latency", 0, 32'(lat), 32'd2);
    chk("alu_lat_rd",  0, 32'(bus.rd), 32'd20);
    chk("alu_lat_wd",  0, bus.wd, 32'hABC);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end
endmodule
